// File: rtl/bht_gshare.sv
// bht_gshare: bimodal/gshare branch history table with speculative global history and checkpoint restore
module bht_gshare #(
  parameter int unsigned NR_ENTRIES      = 128,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned VLEN            = 39,
  parameter int unsigned GHR_WIDTH       = 4,
  parameter bit          GSHARE          = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [GHR_WIDTH-1:0]       ghr_o,
  input  logic                       spec_push_i,
  input  logic                       spec_taken_i,
  input  logic                       restore_i,
  input  logic [GHR_WIDTH-1:0]       restore_ghr_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic [GHR_WIDTH-1:0]       upd_ghr_i,
  input  logic                       upd_taken_i
);
  localparam int unsigned NR_ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_IDX_BITS = $clog2(NR_ROWS);
  localparam int unsigned SLOT_BITS    = $clog2(INSTR_PER_FETCH);
  localparam int unsigned ROW_LSB      = 1 + SLOT_BITS;
  localparam int unsigned SW           = SLOT_BITS > 0 ? SLOT_BITS : 1;
  logic [INSTR_PER_FETCH-1:0] valid_q [NR_ROWS];
  logic [1:0]                 cnt_q [NR_ROWS][INSTR_PER_FETCH];
  logic [GHR_WIDTH-1:0]       ghr_q;
  logic [ROW_IDX_BITS-1:0]    lk_row, up_row;
  logic [SW-1:0]              up_slot;
  logic [1:0]                 up_cnt, nxt_cnt;
  logic                       up_vld;
  logic                       unused_bits;
  function automatic logic [ROW_IDX_BITS-1:0] row_of(input logic [VLEN-1:0] pc, input logic [GHR_WIDTH-1:0] h);
    return pc[ROW_LSB +: ROW_IDX_BITS] ^ (GSHARE ? ROW_IDX_BITS'(h) : '0);
  endfunction
  assign unused_bits = ^{vpc_i, upd_pc_i};
  assign lk_row  = row_of(vpc_i, ghr_q);
  assign up_row  = row_of(upd_pc_i, upd_ghr_i);
  assign up_slot = INSTR_PER_FETCH > 1 ? upd_pc_i[1 +: SW] : '0;
  assign up_vld  = valid_q[up_row][up_slot];
  assign up_cnt  = cnt_q[up_row][up_slot];
  assign ghr_o   = ghr_q;
  always_comb begin
    nxt_cnt = !up_vld ? (upd_taken_i ? 2'b10 : 2'b01)
            : upd_taken_i ? (up_cnt == 2'b11 ? up_cnt : up_cnt + 2'd1)
            : (up_cnt == 2'b00 ? up_cnt : up_cnt - 2'd1);
  end
  for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
    assign pred_valid_o[i] = valid_q[lk_row][i];
    assign pred_taken_o[i] = cnt_q[lk_row][i][1];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ghr_q <= '0;
      for (int r = 0; r < NR_ROWS; r++) begin
        valid_q[r] <= '0;
        for (int s = 0; s < INSTR_PER_FETCH; s++) cnt_q[r][s] <= 2'b00;
      end
    end else if (!debug_mode_i) begin
      if (restore_i) ghr_q <= restore_ghr_i;
      else if (spec_push_i) ghr_q <= GHR_WIDTH'({ghr_q, spec_taken_i});
      if (upd_valid_i) begin
        valid_q[up_row][up_slot] <= 1'b1;
        cnt_q[up_row][up_slot]   <= nxt_cnt;
      end
    end
  end
endmodule

// File: tb/tb_bht_gshare.sv
// tb_bht_gshare: scoreboard bench driving a gshare and a bimodal instance with shared stimulus
module tb_bht_gshare;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, dbg = 1'b0;
  logic push = 1'b0, ptk = 1'b0, restore = 1'b0, uv = 1'b0, ut = 1'b0;
  logic [38:0] vpc = '0, upc = '0;
  logic [3:0]  rghr = '0, ughr = '0;
  logic [1:0]  pv_g, pt_g, pv_b, pt_b;
  logic [3:0]  gh_g, gh_b;
  int n_cmp = 0, n_err = 0;
  typedef struct { string tag; int sel; logic [3:0] exp; } exp_t;
  exp_t sb[$];
  logic       m_v [2][64][2];
  logic [1:0] m_c [2][64][2];
  logic [3:0] m_ghr;

  always #5 clk = ~clk;

  bht_gshare #(.GSHARE(1'b1)) dut_g (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg), .vpc_i(vpc),
    .pred_valid_o(pv_g), .pred_taken_o(pt_g), .ghr_o(gh_g),
    .spec_push_i(push), .spec_taken_i(ptk), .restore_i(restore), .restore_ghr_i(rghr),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ughr), .upd_taken_i(ut));

  bht_gshare #(.GSHARE(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg), .vpc_i(vpc),
    .pred_valid_o(pv_b), .pred_taken_o(pt_b), .ghr_o(gh_b),
    .spec_push_i(push), .spec_taken_i(ptk), .restore_i(restore), .restore_ghr_i(rghr),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ughr), .upd_taken_i(ut));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] mrow(input int m, input logic [38:0] pc, input logic [3:0] h);
    return pc[7:2] ^ (m == 1 ? {2'b00, h} : 6'd0);
  endfunction

  function automatic logic [3:0] mexp(input int m, input logic [38:0] pc);
    logic [5:0] r;
    r = mrow(m, pc, m_ghr);
    return {m_v[m][r][1], m_v[m][r][0], m_c[m][r][1][1], m_c[m][r][0][1]};
  endfunction

  task automatic model_step();
    logic [5:0] r;
    logic s;
    if (rst || flush) begin
      m_ghr = '0;
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 64; i++)
          for (int j = 0; j < 2; j++) begin
            m_v[m][i][j] = 1'b0;
            m_c[m][i][j] = 2'b00;
          end
    end else if (!dbg) begin
      if (uv)
        for (int m = 0; m < 2; m++) begin
          r = mrow(m, upc, ughr);
          s = upc[1];
          if (!m_v[m][r][s]) begin
            m_v[m][r][s] = 1'b1;
            m_c[m][r][s] = ut ? 2'b10 : 2'b01;
          end else if (ut && m_c[m][r][s] != 2'b11) m_c[m][r][s] = m_c[m][r][s] + 2'd1;
          else if (!ut && m_c[m][r][s] != 2'b00) m_c[m][r][s] = m_c[m][r][s] - 2'd1;
        end
      if (restore) m_ghr = rghr;
      else if (push) m_ghr = {m_ghr[2:0], ptk};
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; push = 1'b0; restore = 1'b0; uv = 1'b0;
  endtask

  task automatic upd(input logic [38:0] pc, input logic t, input logic [3:0] h);
    upc = pc; ut = t; ughr = h; uv = 1'b1;
    cycle();
  endtask

  task automatic psh(input logic t);
    push = 1'b1; ptk = t;
    cycle();
  endtask

  task automatic look(input string tag, input logic [38:0] pc, input logic [3:0] eb, input logic [3:0] eg);
    exp_t e;
    vpc = pc;
    sb.push_back('{tag, 0, eb});
    sb.push_back('{tag, 1, eg});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s/%s", e.tag, e.sel ? "gs" : "bi"), e.sel ? {pv_g, pt_g} : {pv_b, pt_b}, e.exp);
    end
  endtask

  task automatic ghr_is(input string tag, input logic [3:0] exp);
    check({tag, "/gs"}, gh_g, exp);
    check({tag, "/bi"}, gh_b, exp);
  endtask

  initial begin
    logic [38:0] p;
    cycle();
    ghr_is("ghr_rst", 4'b0000);
    for (int r = 0; r < 64; r++) look("rst_sweep", {31'd0, 6'(r), 2'b00}, 4'b0000, 4'b0000);

    upd(39'h80, 1'b1, 4'h0);
    upd(39'h80, 1'b1, 4'h0);
    look("train_11", 39'h80, 4'b0101, 4'b0101);
    upd(39'h80, 1'b1, 4'h0);
    look("sat_11", 39'h80, 4'b0101, 4'b0101);
    upd(39'h80, 1'b0, 4'h0);
    upd(39'h80, 1'b0, 4'h0);
    look("down_01", 39'h80, 4'b0100, 4'b0100);
    upd(39'h80, 1'b1, 4'h0);
    look("up_from_01", 39'h80, 4'b0101, 4'b0101);

    rst = 1'b1;
    cycle();
    upd(39'h80, 1'b1, 4'h0);
    psh(1'b1);
    ghr_is("ghr_push1", 4'b0001);
    look("gs_vpc80", 39'h80, 4'b0101, 4'b0000);
    look("gs_vpc84", 39'h84, 4'b0000, 4'b0101);

    psh(1'b0); psh(1'b1); psh(1'b0); psh(1'b1);
    ghr_is("ghr_0101", 4'b0101);
    restore = 1'b1; rghr = 4'b1010; push = 1'b1; ptk = 1'b1;
    cycle();
    ghr_is("restore_wins", 4'b1010);
    psh(1'b0);
    ghr_is("push_after_restore", 4'b0100);

    upd(39'h80, 1'b1, 4'h0);
    look("pre_flush_80", 39'h80, 4'b0101, 4'b0000);
    look("pre_flush_90", 39'h90, 4'b0000, 4'b0101);
    flush = 1'b1; uv = 1'b1; upc = 39'h80; ut = 1'b1; ughr = 4'h0; push = 1'b1; ptk = 1'b1;
    cycle();
    ghr_is("ghr_flush", 4'b0000);
    for (int r = 0; r < 64; r++) look("flush_sweep", {31'd0, 6'(r), 2'b00}, 4'b0000, 4'b0000);

    dbg = 1'b1; uv = 1'b1; upc = 39'h88; ut = 1'b1; ughr = 4'h0; push = 1'b1; ptk = 1'b1;
    cycle();
    ghr_is("ghr_debug", 4'b0000);
    look("debug_no_train", 39'h88, 4'b0000, 4'b0000);
    dbg = 1'b0;
    upd(39'h88, 1'b1, 4'h0);
    look("post_debug", 39'h88, 4'b0101, 4'b0101);
    uv = 1'b1; upc = 39'h88; ut = 1'b0; ughr = 4'h0;
    look("no_bypass", 39'h88, 4'b0101, 4'b0101);
    cycle();
    look("was_10", 39'h88, 4'b0100, 4'b0100);

    rst = 1'b1;
    cycle();
    for (int k = 0; k < 400; k++) begin
      dbg = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 49) == 0);
      uv = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      ughr = 4'($urandom());
      push = 1'($urandom_range(0, 1));
      ptk = 1'($urandom_range(0, 1));
      restore = ($urandom_range(0, 7) == 0);
      rghr = 4'($urandom());
      p = 39'({$urandom(), $urandom()});
      p[7:2] = 6'($urandom_range(0, 7));
      upc = p;
      p = 39'({$urandom(), $urandom()});
      p[7:2] = 6'($urandom_range(0, 7));
      look("rnd", p, mexp(0, p), mexp(1, p));
      ghr_is("rnd_ghr", m_ghr);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bht_gshare.md
Name: bht_gshare

Overview:
- Parametrised successor to the fixed-size bimodal BHT: a branch history table with a selectable indexing mode, either plain bimodal or gshare (PC XOR global history).
- Sits in the frontend beside the BTB and RAS. Its depth and per-fetch width derive from the BHTEntries / fetch-width configuration, and the mode follows BranchPredictorImpl.
- Provides a combinational per-slot prediction for the current fetch PC.
- Maintains a speculative global history register (GHR) with checkpoint restore, and trains 2-bit saturating counters on resolved branches.

Parameters:
- NR_ENTRIES, 128, total counters; power of two; multiple of INSTR_PER_FETCH.
- INSTR_PER_FETCH, 2, 16-bit parcels per fetch block (slots per row); power of two, ≥1.
- VLEN, 39, virtual address width.
- GHR_WIDTH, 4, global history bits; 1 ≤ GHR_WIDTH ≤ ROW_IDX_BITS.
- GSHARE, 1, indexing mode: 0 = bimodal (history ignored), 1 = gshare.

Derived values:
- NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH.
- ROW_IDX_BITS = log2(NR_ROWS).
- SLOT_BITS = log2(INSTR_PER_FETCH).
- ROW_LSB = 1 + SLOT_BITS.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  invalidates every entry and clears the GHR.
- debug_mode_i  in  1  suppresses training and GHR changes while high.
- vpc_i  in  VLEN  fetch PC for lookup.
- pred_valid_o  out  INSTR_PER_FETCH  per slot: entry valid.
- pred_taken_o  out  INSTR_PER_FETCH  per slot: counter MSB.
- ghr_o  out  GHR_WIDTH  current speculative history, used by the frontend as a checkpoint.
- spec_push_i  in  1  a conditional branch was predicted this cycle.
- spec_taken_i  in  1  direction shifted into the GHR.
- restore_i  in  1  mispredict; load the GHR from restore_ghr_i.
- restore_ghr_i  in  GHR_WIDTH  corrected history (checkpoint with the resolved outcome already appended).
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  VLEN  PC of that branch.
- upd_ghr_i  in  GHR_WIDTH  GHR checkpoint captured at its prediction.
- upd_taken_i  in  1  resolved direction.

Behaviour:
- Storage: NR_ROWS × INSTR_PER_FETCH entries. Each entry is a valid bit plus a 2-bit counter, held in flops.
- Row index:
  - base = pc[ROW_LSB +: ROW_IDX_BITS].
  - GSHARE=1: the low GHR_WIDTH bits of base are XORed with the GHR (ghr_o for lookup, upd_ghr_i for update). Upper bits pass through unchanged.
  - GSHARE=0: index = base.
- Slot index: pc[1 +: SLOT_BITS]; slot 0 when INSTR_PER_FETCH=1.
- Lookup:
  - Zero latency, purely combinational from registered state.
  - Slot i outputs valid[row][i] and counter[row][i][1].
  - Lookup and update hitting the same entry in the same cycle: lookup returns the pre-update value; there is no bypass.
- Training: on upd_valid_i && !debug_mode_i && !flush_i, the addressed entry is updated at the next edge.
  - If invalid: set valid=1 and counter = taken ? 2'b10 : 2'b01.
  - If valid: saturating ±1. Counter holds at 2'b11 on taken and at 2'b00 on not-taken.
- GHR, one update per cycle. Priority: rst_i/flush_i > debug_mode_i (hold) > restore_i > spec_push_i.
  - restore_i: ghr <= restore_ghr_i. A simultaneous push is dropped.
  - spec_push_i: ghr <= {ghr[GHR_WIDTH-2:0], spec_taken_i}. For GHR_WIDTH=1: ghr <= spec_taken_i.
- Reset and flush:
  - rst_i or flush_i: at the next edge all valid bits = 0, all counters = 2'b00, ghr = 0.
  - This overrides any concurrent update, push or restore, including reset in the middle of a training burst.
  - Outputs after reset: pred_valid_o = 0, pred_taken_o = 0, ghr_o = 0.
- Width rule: upd_pc_i and vpc_i bits above ROW_LSB+ROW_IDX_BITS are ignored. Aliasing is permitted.

Test Plan:
1. Assert rst_i for 1 cycle, then sweep vpc_i over all rows → pred_valid_o=0, pred_taken_o=0, ghr_o=0 everywhere.
2. GSHARE=0, update pc 0x80 taken twice → lookup vpc 0x80 gives slot0 valid=1, taken=1 (counter 11). A third taken update keeps it at 11. Two not-taken updates → counter 01, taken=0. Slot1 stays invalid.
3. GSHARE=1, ghr=0: update pc 0x80 (row 0x20) taken with upd_ghr_i=0, then push taken (ghr_o=0001).
   - Lookup vpc 0x80 → row 0x21, slot0 valid=0.
   - Lookup vpc 0x84 → row 0x21^1=0x20, slot0 valid=1, taken=1.
4. With ghr=0101, assert restore_i (restore_ghr_i=1010) together with spec_push_i/taken=1 → ghr_o=1010. Next cycle, push not-taken → ghr_o=0100.
5. Train pc 0x80 to 11, then assert flush_i in the same cycle as upd_valid_i and spec_push_i → next cycle all entries invalid, ghr_o=0000.
6. With debug_mode_i=1, apply an update to pc 0x88 (slot 0 of row 0x22) and a push → entry stays invalid, ghr unchanged. Drop debug_mode_i, repeat the same update → slot0 at vpc 0x88 shows valid=1, counter 10.
